// File: rtl/econet_hdlc_tx.sv
// Econet HDLC bit transmitter: 0x7E flags, LSB-first bytes, zero-bit stuffing, driver enable.
// Define ECONET_TX_ABORT_EN to add the abort port and the eight-ones abort sequence.
module econet_hdlc_tx #(
    parameter int unsigned PREAMBLE_FLAGS = 1,
    parameter int unsigned CLOSING_FLAGS  = 1
) (
    input  logic       econet_clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       start_frame,
    input  logic       end_frame,
`ifdef ECONET_TX_ABORT_EN
    input  logic       abort,
`endif
    output logic       request_byte,
    output logic       econet_data,
    output logic       transmitting
);

    localparam logic [7:0] FLAG       = 8'h7E;
    localparam logic [3:0] PRE_LAST   = 4'(PREAMBLE_FLAGS - 1);
    localparam logic [3:0] CLOSE_LAST = 4'(CLOSING_FLAGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StData,
        StClose
`ifdef ECONET_TX_ABORT_EN
        ,
        StAbort
`endif
    } state_e;

    state_e      state_q;
    logic [7:0]  shifter_q;
    logic [2:0]  bit_cnt_q;
    logic [3:0]  flag_cnt_q;
    logic [2:0]  ones_cnt_q;
    logic        load_pend_q;

    logic [2:0]  bit_idx_next;
    logic        data_bit_next;
    logic        flag_bit_next;
    logic [2:0]  ones_inc;

    assign bit_idx_next  = bit_cnt_q + 3'd1;
    assign data_bit_next = shifter_q[bit_idx_next];
    assign flag_bit_next = FLAG[bit_idx_next];
    assign ones_inc      = ones_cnt_q + 3'd1;

    // request_byte is delayed one period from the load so it lands on bit1 of the new byte.
    always_ff @(negedge econet_clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            econet_data  <= 1'b1;
            transmitting <= 1'b0;
            request_byte <= 1'b0;
            shifter_q    <= '0;
            bit_cnt_q    <= '0;
            flag_cnt_q   <= '0;
            ones_cnt_q   <= '0;
            load_pend_q  <= 1'b0;
        end else begin
            request_byte <= load_pend_q;
            load_pend_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    econet_data  <= 1'b1;
                    transmitting <= 1'b0;
                    if (start_frame) begin
                        state_q      <= StPreamble;
                        econet_data  <= FLAG[0];
                        transmitting <= 1'b1;
                        bit_cnt_q    <= 3'd0;
                        flag_cnt_q   <= 4'd0;
                        ones_cnt_q   <= 3'd0;
                    end
                end
                StPreamble: begin
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_q   <= bit_idx_next;
                        econet_data <= flag_bit_next;
                    end else if (flag_cnt_q != PRE_LAST) begin
                        flag_cnt_q  <= flag_cnt_q + 4'd1;
                        bit_cnt_q   <= 3'd0;
                        econet_data <= FLAG[0];
                    end else begin
                        bit_cnt_q   <= 3'd0;
                        load_pend_q <= 1'b1;
                        if (end_frame) begin
                            state_q     <= StClose;
                            flag_cnt_q  <= 4'd0;
                            ones_cnt_q  <= 3'd0;
                            econet_data <= FLAG[0];
                        end else begin
                            state_q     <= StData;
                            shifter_q   <= tx_byte;
                            econet_data <= tx_byte[0];
                            ones_cnt_q  <= {2'b00, tx_byte[0]};
                        end
                    end
                end
                StData: begin
                    if (ones_cnt_q == 3'd5) begin
                        // Stuffed zero: shifter and bit position hold for one period.
                        econet_data <= 1'b0;
                        ones_cnt_q  <= 3'd0;
                    end else if (bit_cnt_q != 3'd7) begin
                        bit_cnt_q   <= bit_idx_next;
                        econet_data <= data_bit_next;
                        ones_cnt_q  <= data_bit_next ? ones_inc : 3'd0;
                    end else begin
                        bit_cnt_q   <= 3'd0;
                        load_pend_q <= 1'b1;
                        if (end_frame) begin
                            state_q     <= StClose;
                            flag_cnt_q  <= 4'd0;
                            ones_cnt_q  <= 3'd0;
                            econet_data <= FLAG[0];
                        end else begin
                            shifter_q   <= tx_byte;
                            econet_data <= tx_byte[0];
                            ones_cnt_q  <= tx_byte[0] ? ones_inc : 3'd0;
                        end
                    end
                end
                StClose: begin
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_q   <= bit_idx_next;
                        econet_data <= flag_bit_next;
                    end else if (flag_cnt_q != CLOSE_LAST) begin
                        flag_cnt_q  <= flag_cnt_q + 4'd1;
                        bit_cnt_q   <= 3'd0;
                        econet_data <= FLAG[0];
                    end else begin
                        state_q      <= StIdle;
                        bit_cnt_q    <= 3'd0;
                        econet_data  <= 1'b1;
                        transmitting <= 1'b0;
                    end
                end
`ifdef ECONET_TX_ABORT_EN
                StAbort: begin
                    econet_data <= 1'b1;
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_q <= bit_idx_next;
                    end else begin
                        state_q      <= StIdle;
                        bit_cnt_q    <= 3'd0;
                        transmitting <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q      <= StIdle;
                    econet_data  <= 1'b1;
                    transmitting <= 1'b0;
                end
            endcase
`ifdef ECONET_TX_ABORT_EN
            // Abort overrides whatever the active state scheduled for this edge.
            if (abort && (state_q == StPreamble || state_q == StData || state_q == StClose)) begin
                state_q      <= StAbort;
                econet_data  <= 1'b1;
                transmitting <= 1'b1;
                bit_cnt_q    <= 3'd0;
                ones_cnt_q   <= 3'd0;
                request_byte <= 1'b0;
                load_pend_q  <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_econet_hdlc_tx.sv
// Directed bench for econet_hdlc_tx: table of frames with hand-computed line bit streams.
module tb_econet_hdlc_tx;

    logic       econet_clk = 1'b0;
    logic       reset;
    logic [7:0] tx_byte;
    logic       start_frame;
    logic       end_frame;
    logic       start2;
    logic       end2;
`ifdef ECONET_TX_ABORT_EN
    logic       abort;
`endif
    logic       request_byte, econet_data, transmitting;
    logic       request2, data2, tx2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] up_bytes [2];
    int         up_n;
    int         up_idx;

    always #5 econet_clk = ~econet_clk;

    econet_hdlc_tx dut (
        .econet_clk  (econet_clk),
        .reset       (reset),
        .tx_byte     (tx_byte),
        .start_frame (start_frame),
        .end_frame   (end_frame),
`ifdef ECONET_TX_ABORT_EN
        .abort       (abort),
`endif
        .request_byte(request_byte),
        .econet_data (econet_data),
        .transmitting(transmitting)
    );

    econet_hdlc_tx #(
        .PREAMBLE_FLAGS(2),
        .CLOSING_FLAGS (2)
    ) dut2 (
        .econet_clk  (econet_clk),
        .reset       (reset),
        .tx_byte     (tx_byte),
        .start_frame (start2),
        .end_frame   (end2),
`ifdef ECONET_TX_ABORT_EN
        .abort       (abort),
`endif
        .request_byte(request2),
        .econet_data (data2),
        .transmitting(tx2)
    );

    // bits[i] / req[i] are the line bit and request_byte during the i-th transmitted period.
    typedef struct {
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          len;
        logic [47:0] bits;
        logic [47:0] req;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic present();
        tx_byte   = (up_idx < up_n) ? up_bytes[up_idx] : 8'h00;
        end_frame = (up_idx >= up_n);
    endtask

    // Sample point is the posedge; the DUT changes only on negedge.
    task automatic tick();
        @(posedge econet_clk);
        if (request_byte) begin
            up_idx++;
            present();
        end
    endtask

    task automatic load_frame(input int n, input logic [7:0] b0, input logic [7:0] b1);
        up_bytes[0] = b0;
        up_bytes[1] = b1;
        up_n        = n;
        up_idx      = 0;
        present();
    endtask

    logic [31:0] four_flags;

    initial begin
        vecs[0] = '{nbytes: 2, b0: 8'h12, b1: 8'h34, len: 32,
                    bits: 48'h7E34127E, req: 48'h02020200};
        vecs[1] = '{nbytes: 2, b0: 8'hFF, b1: 8'h01, len: 33,
                    bits: 48'({8'h7E, 8'h01, 9'b111011111, 8'h7E}), req: 48'h04040200};
        vecs[2] = '{nbytes: 2, b0: 8'h1F, b1: 8'hF8, len: 34,
                    bits: 48'({8'h7E, 9'b011111000, 9'b000011111, 8'h7E}), req: 48'h08040200};
        vecs[3] = '{nbytes: 1, b0: 8'h7E, b1: 8'h00, len: 25,
                    bits: 48'({8'h7E, 9'b010111110, 8'h7E}), req: 48'h00040200};
        vecs[4] = '{nbytes: 0, b0: 8'h00, b1: 8'h00, len: 16,
                    bits: 48'({8'h7E, 8'h7E}), req: 48'h00000200};
        four_flags = 32'h7E7E7E7E;

        reset       = 1'b1;
        start_frame = 1'b0;
        start2      = 1'b0;
        end2        = 1'b1;
        tx_byte     = 8'h00;
        end_frame   = 1'b0;
`ifdef ECONET_TX_ABORT_EN
        abort       = 1'b0;
`endif
        up_n   = 0;
        up_idx = 0;

        #1;
        check("reset data", econet_data, 1'b1);
        check("reset tx", transmitting, 1'b0);
        check("reset req", request_byte, 1'b0);
        repeat (2) @(posedge econet_clk);
        #1 reset = 1'b0;

        // Idle with no start
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle%0d data", i), econet_data, 1'b1);
            check($sformatf("idle%0d tx", i), transmitting, 1'b0);
            check($sformatf("idle%0d req", i), request_byte, 1'b0);
        end

        // Table-driven frames on the default-parameter instance
        for (int v = 0; v < 5; v++) begin
            load_frame(vecs[v].nbytes, vecs[v].b0, vecs[v].b1);
            start_frame = 1'b1;
            for (int i = 0; i < vecs[v].len; i++) begin
                tick();
                start_frame = 1'b0;
                check($sformatf("v%0d bit%0d data", v, i), econet_data, vecs[v].bits[i]);
                check($sformatf("v%0d bit%0d tx", v, i), transmitting, 1'b1);
                check($sformatf("v%0d bit%0d req", v, i), request_byte, vecs[v].req[i]);
            end
            tick();
            check($sformatf("v%0d end data", v), econet_data, 1'b1);
            check($sformatf("v%0d end tx", v), transmitting, 1'b0);
            tick();
            check($sformatf("v%0d idle tx", v), transmitting, 1'b0);
        end

        // Empty frame, two preamble and two closing flags
        start2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            start2 = 1'b0;
            check($sformatf("e2 bit%0d data", i), data2, four_flags[i]);
            check($sformatf("e2 bit%0d tx", i), tx2, 1'b1);
            check($sformatf("e2 bit%0d req", i), request2, (i == 17));
        end
        tick();
        check("e2 end data", data2, 1'b1);
        check("e2 end tx", tx2, 1'b0);

        // Async reset mid-byte while a 0 bit is on the line
        load_frame(2, 8'h12, 8'h34);
        start_frame = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            start_frame = 1'b0;
        end
        check("rst pre data", econet_data, 1'b0);
        check("rst pre tx", transmitting, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst mid data", econet_data, 1'b1);
        check("rst mid tx", transmitting, 1'b0);
        check("rst mid req", request_byte, 1'b0);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("post rst%0d tx", i), transmitting, 1'b0);
            check($sformatf("post rst%0d data", i), econet_data, 1'b1);
        end

`ifdef ECONET_TX_ABORT_EN
        // Abort mid-DATA: eight ones, then idle, no request
        load_frame(2, 8'h00, 8'h00);
        start_frame = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            start_frame = 1'b0;
        end
        check("abt pre data", econet_data, 1'b0);
        abort = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            abort = 1'b0;
            check($sformatf("abt%0d data", i), econet_data, 1'b1);
            check($sformatf("abt%0d tx", i), transmitting, 1'b1);
            check($sformatf("abt%0d req", i), request_byte, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("abt idle%0d tx", i), transmitting, 1'b0);
            check($sformatf("abt idle%0d data", i), econet_data, 1'b1);
            check($sformatf("abt idle%0d req", i), request_byte, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
